bsg_manycore_edge_sink: RTL and testbench
=========================================

// Module: bsg_manycore_edge_sink
// PURPOSE
//  Replaces the passive link_sif tie-offs on the unused edges of the manycore array (W/E/N/S, unused io).
//  Every request that reaches a dead edge is answered, so the requesting tile never hangs on credits or a load.
//  Each stray event is counted, and the first offending packet per channel is captured for host readout.
//  Sits in the manycore wrapper: one instance per edge, with num_channels_p links on that edge.
// PARAMETERS
//  num_channels_p  1             number of edge links served
//  addr_width_p    "inv"         manycore packet EPA width (words)
//  data_width_p    "inv"         packet data width
//  x_cord_width_p  "inv"         x coordinate width
//  y_cord_width_p  "inv"         y coordinate width
//  count_width_p   16            per-channel saturating stray counter width
//  error_data_p    32'hDEADBEEF  load-return data, truncated/zero-extended to data_width_p
// PORTS
//  clk_i         in   1                     clock
//  reset_i       in   1                     asynchronous reset, active-high
//  link_sif_i    in   [num_channels_p][lsw]  array-side link outputs; lsw=`bsg_manycore_link_sif_width(..)
//  link_sif_o    out  [num_channels_p][lsw]  links driven back into the array
//  clear_i       in   1                     synchronous clear of all counters and captures
//  err_v_o       out  [num_channels_p]      sticky: channel has seen >=1 stray fwd packet
//  fwd_count_o   out  [num_channels_p][count_width_p]  stray fwd packets accepted (saturating)
//  rev_count_o   out  [num_channels_p][count_width_p]  stray rev packets accepted (saturating)
//  cap_pkt_o     out  [num_channels_p][pw]  first captured fwd packet; pw=packet width
// BEHAVIOUR
//  Reset values: all outputs 0, every valid in link_sif_o 0, and fwd ready_and 1.
//  Fwd out (toward the array): v always 0. The edge never originates requests.
//  Rev in (stray responses): ready_and always 1. Each accepted beat increments rev_count.
//  Fwd in (stray requests) per channel:
//   fwd ready_and_o = ~ret_v_r | rev_ready_and_i, so back-to-back accepts are possible at 1 pkt/cycle.
//   On accept (v & ready), the return register loads on the next clk edge:
//     pkt_type = e_return_int_wb for e_remote_load.
//     pkt_type = e_return_credit for e_remote_store and e_remote_amo*.
//     data = error_data_p for loads, else 0.
//     reg_id = echoed from the request.
//     y/x_cord = src_y/src_x of the request.
//   Latency: accept in cycle N -> rev v_o asserted in cycle N+1.
//   ret_v_r is held, with stable contents, until rev ready_and_i.
//   Accepting a new packet in the same cycle ret_v_r drains reloads the register, with no bubble.
//  Counters:
//   Increment by 1 per accepted beat and saturate at 2^count_width_p-1. They never wrap.
//   clear_i zeroes counters, err_v_o and cap_pkt_o on the next edge.
//   clear_i together with an event in the same cycle: counter=1, err_v=1, and the new packet is captured (event wins).
//  Capture: cap_pkt_o loads on an accept while err_v_o==0. It then holds until clear_i or reset.
//  Reset mid-operation: any pending return is discarded, and the requester is not answered.
//   Software re-initialises tiles after reset.
//  Channels are fully independent. There is no arbitration between channels.
// STRUCTURE
//  Package (bsg_manycore_pkg): add typedef edge_sink_status_s {err_v, fwd_count, rev_count}.
//   Packet/return-packet structs come from the existing declare macros.
//  Sub-module bsg_manycore_edge_sink_channel: one link. It holds the return register, 2 counters and the capture.
//   The top level is a generate loop plus link_sif struct casts.
// TESTING
//  1. Load (src 2,3, reg_id 5) on ch0 with rev ready=1 -> return int_wb in the next cycle.
//     data=DEADBEEF, reg 5, dest (2,3). fwd_count=1, err_v=1, cap matches.
//  2. 4 back-to-back stores, rev ready=1 -> 4 credit returns on consecutive cycles.
//     fwd ready stays 1 and fwd_count=4.
//  3. rev ready held 0 for 5 cycles after a load -> fwd ready=0 and the return stays stable.
//     A second request is stalled until release, then served the cycle after.
//  4. count_width_p=2 with 6 stray rev beats -> rev_count sticks at 3.
//     clear_i coincident with a 7th beat -> rev_count=1.
//  5. Second packet with a different addr after the first -> cap_pkt keeps the first.
//     clear_i, then a third packet -> cap = third.
//  6. Assert reset_i asynchronously mid-cycle while a return is pending -> rev v drops immediately.
//     Counters=0, and after release fwd ready=1.

Source files
------------

// File: rtl/bsg_manycore_edge_sink_pkg.sv
// Shared encodings and width helpers for the manycore edge sink.
// Packet layouts mirror the manycore link_sif packet declare macros.
package bsg_manycore_edge_sink_pkg;

    localparam int op_width_lp          = 4;
    localparam int reg_id_width_lp      = 5;
    localparam int return_type_width_lp = 2;

    typedef enum logic [op_width_lp-1:0] {
        e_remote_load    = 4'd0,
        e_remote_store   = 4'd1,
        e_remote_sw      = 4'd2,
        e_remote_amoswap = 4'd3,
        e_remote_amoadd  = 4'd4,
        e_remote_amoxor  = 4'd5,
        e_remote_amoand  = 4'd6,
        e_remote_amoor   = 4'd7
    } bsg_manycore_packet_op_e;

    typedef enum logic [return_type_width_lp-1:0] {
        e_return_credit   = 2'd0,
        e_return_int_wb   = 2'd1,
        e_return_float_wb = 2'd2,
        e_return_ifetch   = 2'd3
    } bsg_manycore_return_packet_type_e;

    function automatic int packet_width(input int a, input int d, input int x, input int y);
        return a + op_width_lp + reg_id_width_lp + d + 2 * (x + y);
    endfunction

    function automatic int return_packet_width(input int d, input int x, input int y);
        return return_type_width_lp + d + reg_id_width_lp + x + y;
    endfunction

    // Two link halves, each {v, ready_and_rev, data}.
    function automatic int link_sif_width(input int a, input int d, input int x, input int y);
        return 4 + packet_width(a, d, x, y) + return_packet_width(d, x, y);
    endfunction

endpackage

// File: rtl/bsg_manycore_edge_sink_channel.sv
// One dead-edge link: answers every stray request, counts stray traffic
// and latches the first offending request until cleared.
module bsg_manycore_edge_sink_channel
    import bsg_manycore_edge_sink_pkg::*;
#(
    parameter int          addr_width_p   = 28,
    parameter int          data_width_p   = 32,
    parameter int          x_cord_width_p = 7,
    parameter int          y_cord_width_p = 7,
    parameter int          count_width_p  = 16,
    parameter logic [31:0] error_data_p   = 32'hDEADBEEF,
    localparam int pw_lp = packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int rw_lp = return_packet_width(data_width_p, x_cord_width_p, y_cord_width_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     fwd_v_i,
    input  logic [pw_lp-1:0]         fwd_pkt_i,
    output logic                     fwd_ready_and_o,
    input  logic                     rev_v_i,
    output logic                     ret_v_o,
    output logic [rw_lp-1:0]         ret_pkt_o,
    input  logic                     ret_ready_and_i,
    output logic                     err_v_o,
    output logic [count_width_p-1:0] fwd_count_o,
    output logic [count_width_p-1:0] rev_count_o,
    output logic [pw_lp-1:0]         cap_pkt_o
);

    typedef struct packed {
        logic [addr_width_p-1:0]     addr;
        bsg_manycore_packet_op_e     op;
        logic [reg_id_width_lp-1:0]  reg_id;
        logic [data_width_p-1:0]     payload;
        logic [y_cord_width_p-1:0]   src_y;
        logic [x_cord_width_p-1:0]   src_x;
        logic [y_cord_width_p-1:0]   y_cord;
        logic [x_cord_width_p-1:0]   x_cord;
    } packet_s;

    typedef struct packed {
        bsg_manycore_return_packet_type_e pkt_type;
        logic [data_width_p-1:0]          data;
        logic [reg_id_width_lp-1:0]       reg_id;
        logic [y_cord_width_p-1:0]        y_cord;
        logic [x_cord_width_p-1:0]        x_cord;
    } return_packet_s;

    typedef struct packed {
        logic                     err_v;
        logic [count_width_p-1:0] fwd_count;
        logic [count_width_p-1:0] rev_count;
    } edge_sink_status_s;

    function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] c,
                                                         input logic en);
        return (en && c != '1) ? c + count_width_p'(1) : c;
    endfunction

    packet_s           fwd_pkt;
    return_packet_s    ret_r, ret_n;
    logic              ret_v_r, fwd_accept, cap_en;
    edge_sink_status_s status_r, status_n;
    logic [pw_lp-1:0]  cap_r;

    assign fwd_pkt         = packet_s'(fwd_pkt_i);
    assign fwd_ready_and_o = ~ret_v_r | ret_ready_and_i;
    assign fwd_accept      = fwd_v_i & fwd_ready_and_o;

    always_comb begin
        ret_n          = '0;
        ret_n.reg_id   = fwd_pkt.reg_id;
        ret_n.y_cord   = fwd_pkt.src_y;
        ret_n.x_cord   = fwd_pkt.src_x;
        ret_n.pkt_type = e_return_credit;
        if (fwd_pkt.op == e_remote_load) begin
            ret_n.pkt_type = e_return_int_wb;
            ret_n.data     = data_width_p'(error_data_p);
        end
    end

    // Clear is applied first so a same-cycle event still lands on top of it.
    always_comb begin
        status_n = status_r;
        if (clear_i) status_n = '0;
        cap_en             = fwd_accept & ~status_n.err_v;
        status_n.err_v     = status_n.err_v | fwd_accept;
        status_n.fwd_count = sat_inc(status_n.fwd_count, fwd_accept);
        status_n.rev_count = sat_inc(status_n.rev_count, rev_v_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ret_v_r  <= 1'b0;
            ret_r    <= '0;
            status_r <= '0;
            cap_r    <= '0;
        end else begin
            status_r <= status_n;
            if (cap_en)       cap_r <= fwd_pkt_i;
            else if (clear_i) cap_r <= '0;
            if (fwd_accept) begin
                ret_v_r <= 1'b1;
                ret_r   <= ret_n;
            end else if (ret_ready_and_i) begin
                ret_v_r <= 1'b0;
            end
        end
    end

    assign ret_v_o     = ret_v_r;
    assign ret_pkt_o   = ret_r;
    assign err_v_o     = status_r.err_v;
    assign fwd_count_o = status_r.fwd_count;
    assign rev_count_o = status_r.rev_count;
    assign cap_pkt_o   = cap_r;

endmodule

// File: rtl/bsg_manycore_edge_sink.sv
// Active terminator for the unused edge links of the manycore array:
// one independent sink channel per link.
module bsg_manycore_edge_sink
    import bsg_manycore_edge_sink_pkg::*;
#(
    parameter int          num_channels_p = 1,
    parameter int          addr_width_p   = 28,
    parameter int          data_width_p   = 32,
    parameter int          x_cord_width_p = 7,
    parameter int          y_cord_width_p = 7,
    parameter int          count_width_p  = 16,
    parameter logic [31:0] error_data_p   = 32'hDEADBEEF,
    localparam int pw_lp  = packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int rw_lp  = return_packet_width(data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int lsw_lp = link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p)
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic [num_channels_p-1:0][lsw_lp-1:0]         link_sif_i,
    output logic [num_channels_p-1:0][lsw_lp-1:0]         link_sif_o,
    input  logic                                          clear_i,
    output logic [num_channels_p-1:0]                     err_v_o,
    output logic [num_channels_p-1:0][count_width_p-1:0]  fwd_count_o,
    output logic [num_channels_p-1:0][count_width_p-1:0]  rev_count_o,
    output logic [num_channels_p-1:0][pw_lp-1:0]          cap_pkt_o
);

    typedef struct packed {
        logic             v;
        logic             ready_and_rev;
        logic [pw_lp-1:0] data;
    } fwd_link_sif_s;

    typedef struct packed {
        logic             v;
        logic             ready_and_rev;
        logic [rw_lp-1:0] data;
    } rev_link_sif_s;

    typedef struct packed {
        fwd_link_sif_s fwd;
        rev_link_sif_s rev;
    } link_sif_s;

    link_sif_s [num_channels_p-1:0] link_in;
    assign link_in = link_sif_i;

    for (genvar i = 0; i < num_channels_p; i++) begin : ch
        logic             fwd_ready, ret_v;
        logic [rw_lp-1:0] ret_pkt;
        link_sif_s        link_out;
        logic             unused_bits;

        bsg_manycore_edge_sink_channel #(
            .addr_width_p  (addr_width_p),
            .data_width_p  (data_width_p),
            .x_cord_width_p(x_cord_width_p),
            .y_cord_width_p(y_cord_width_p),
            .count_width_p (count_width_p),
            .error_data_p  (error_data_p)
        ) chan (
            .clk_i          (clk_i),
            .reset_i        (reset_i),
            .clear_i        (clear_i),
            .fwd_v_i        (link_in[i].fwd.v),
            .fwd_pkt_i      (link_in[i].fwd.data),
            .fwd_ready_and_o(fwd_ready),
            .rev_v_i        (link_in[i].rev.v),
            .ret_v_o        (ret_v),
            .ret_pkt_o      (ret_pkt),
            .ret_ready_and_i(link_in[i].rev.ready_and_rev),
            .err_v_o        (err_v_o[i]),
            .fwd_count_o    (fwd_count_o[i]),
            .rev_count_o    (rev_count_o[i]),
            .cap_pkt_o      (cap_pkt_o[i])
        );

        // Stray response contents and the array's fwd credit are irrelevant here.
        assign unused_bits = ^{link_in[i].fwd.ready_and_rev, link_in[i].rev.data};

        always_comb begin
            link_out                   = '0;
            link_out.fwd.ready_and_rev = fwd_ready;
            link_out.rev.v             = ret_v;
            link_out.rev.ready_and_rev = 1'b1;
            link_out.rev.data          = ret_pkt;
        end

        assign link_sif_o[i] = link_out;
    end

endmodule

// File: tb/tb_bsg_manycore_edge_sink.sv
// Self-checking bench for bsg_manycore_edge_sink: directed scenarios,
// a table of request vectors and a randomized run against a queue model.
module tb_bsg_manycore_edge_sink;
    import bsg_manycore_edge_sink_pkg::*;

    localparam int A   = 16;
    localparam int D   = 32;
    localparam int X   = 4;
    localparam int Y   = 3;
    localparam int PW  = packet_width(A, D, X, Y);
    localparam int LSW = link_sif_width(A, D, X, Y);

    typedef struct packed {
        logic [A-1:0] addr;
        logic [3:0]   op;
        logic [4:0]   reg_id;
        logic [D-1:0] payload;
        logic [Y-1:0] src_y;
        logic [X-1:0] src_x;
        logic [Y-1:0] y_cord;
        logic [X-1:0] x_cord;
    } pkt_t;

    typedef struct packed {
        logic [1:0]   typ;
        logic [D-1:0] data;
        logic [4:0]   reg_id;
        logic [Y-1:0] y_cord;
        logic [X-1:0] x_cord;
    } ret_t;

    typedef struct packed { logic v; logic rdy; pkt_t data; } fwd_t;
    typedef struct packed { logic v; logic rdy; ret_t data; } rev_t;
    typedef struct packed { fwd_t fwd; rev_t rev; } sif_t;

    typedef struct {
        logic [3:0]   op;
        logic [4:0]   reg_id;
        logic [X-1:0] sx;
        logic [Y-1:0] sy;
        logic [1:0]   etyp;
        logic [31:0]  edata;
    } vec_t;

    logic clk, rst, clear, clear2;
    sif_t [1:0] in_s, out_s;
    sif_t [0:0] in2, out2;
    logic [1:0][LSW-1:0] link_in, link_out;
    logic [0:0][LSW-1:0] link_in2, link_out2;
    logic [1:0]          err_v;
    logic [1:0][15:0]    fc, rc;
    logic [1:0][PW-1:0]  cap;
    logic [0:0]          err2;
    logic [0:0][1:0]     fc2, rc2;
    logic [0:0][PW-1:0]  cap2;

    assign link_in  = in_s;
    assign out_s    = link_out;
    assign link_in2 = in2;
    assign out2     = link_out2;

    bsg_manycore_edge_sink #(
        .num_channels_p(2), .addr_width_p(A), .data_width_p(D),
        .x_cord_width_p(X), .y_cord_width_p(Y), .count_width_p(16)
    ) dut (
        .clk_i(clk), .reset_i(rst), .link_sif_i(link_in), .link_sif_o(link_out),
        .clear_i(clear), .err_v_o(err_v), .fwd_count_o(fc), .rev_count_o(rc), .cap_pkt_o(cap)
    );

    bsg_manycore_edge_sink #(
        .num_channels_p(1), .addr_width_p(A), .data_width_p(D),
        .x_cord_width_p(X), .y_cord_width_p(Y), .count_width_p(2)
    ) dut_small (
        .clk_i(clk), .reset_i(rst), .link_sif_i(link_in2), .link_sif_o(link_out2),
        .clear_i(clear2), .err_v_o(err2), .fwd_count_o(fc2), .rev_count_o(rc2), .cap_pkt_o(cap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic pkt_t mk_pkt(input logic [3:0] op, input logic [4:0] rid,
                                    input logic [X-1:0] sx, input logic [Y-1:0] sy,
                                    input logic [A-1:0] addr);
        pkt_t p;
        p         = '0;
        p.op      = op;
        p.reg_id  = rid;
        p.src_x   = sx;
        p.src_y   = sy;
        p.addr    = addr;
        p.payload = 32'h1234_0000 | 32'(addr);
        p.x_cord  = X'(7);
        p.y_cord  = Y'(1);
        return p;
    endfunction

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.addr    = A'($urandom);
        p.op      = 4'($urandom_range(0, 7));
        p.reg_id  = 5'($urandom);
        p.payload = $urandom;
        p.src_y   = Y'($urandom);
        p.src_x   = X'($urandom);
        p.y_cord  = Y'($urandom);
        p.x_cord  = X'($urandom);
        return p;
    endfunction

    // Expected answer: loads get a write-back of the error word, everything else a credit.
    function automatic ret_t exp_ret(input pkt_t p);
        ret_t r;
        r.reg_id = p.reg_id;
        r.y_cord = p.src_y;
        r.x_cord = p.src_x;
        if (p.op == 4'(e_remote_load)) begin
            r.typ  = 2'(e_return_int_wb);
            r.data = 32'hDEADBEEF;
        end else begin
            r.typ  = 2'(e_return_credit);
            r.data = '0;
        end
        return r;
    endfunction

    vec_t tbl[7];
    ret_t mq[2][$];
    int   mf[2], mr[2];
    bit   me[2];
    pkt_t mc[2];

    initial begin
        pkt_t p, pa, pb;
        ret_t e;
        bit   acc[2];
        logic [63:0] rnd;

        rst = 1'b1; clear = 1'b0; clear2 = 1'b0;
        in_s = '0; in2 = '0;
        in_s[0].rev.rdy = 1'b1; in_s[1].rev.rdy = 1'b1; in2[0].rev.rdy = 1'b1;
        #12;
        chk("reset fwd_v_out", out_s[0].fwd.v, 0);
        chk("reset fwd_ready", out_s[0].fwd.rdy, 1);
        chk("reset ret_v", out_s[0].rev.v, 0);
        chk("reset rev_ready", out_s[1].rev.rdy, 1);
        chk("reset counts", {fc, rc}, 0);
        chk("reset err_cap", {err_v, cap}, 0);
        chk("reset small", {err2, fc2, rc2, cap2}, 0);
        rst = 1'b0;
        step();

        // single load answered next cycle
        p = mk_pkt(4'(e_remote_load), 5'd5, X'(2), Y'(3), A'(16'h0040));
        in_s[0].fwd.v = 1'b1; in_s[0].fwd.data = p;
        #1;
        chk("t1 ready", out_s[0].fwd.rdy, 1);
        step();
        in_s[0].fwd.v = 1'b0;
        e.typ = 2'd1; e.data = 32'hDEADBEEF; e.reg_id = 5'd5; e.y_cord = Y'(3); e.x_cord = X'(2);
        chk("t1 ret_v", out_s[0].rev.v, 1);
        chk("t1 ret_pkt", out_s[0].rev.data, e);
        chk("t1 fwd_count", fc[0], 1);
        chk("t1 err_v", err_v[0], 1);
        chk("t1 cap", cap[0], p);
        chk("t1 fwd_v_out", out_s[0].fwd.v, 0);
        chk("t1 other channel", {fc[1], err_v[1]}, 0);
        step();
        chk("t1 drained", out_s[0].rev.v, 0);

        // table of back-to-back requests, starting with four stores
        tbl[0] = '{4'(e_remote_store),   5'd1,  X'(0),  Y'(0), 2'd0, 32'h0};
        tbl[1] = '{4'(e_remote_store),   5'd2,  X'(15), Y'(7), 2'd0, 32'h0};
        tbl[2] = '{4'(e_remote_store),   5'd31, X'(3),  Y'(1), 2'd0, 32'h0};
        tbl[3] = '{4'(e_remote_store),   5'd0,  X'(9),  Y'(4), 2'd0, 32'h0};
        tbl[4] = '{4'(e_remote_load),    5'd17, X'(5),  Y'(6), 2'd1, 32'hDEADBEEF};
        tbl[5] = '{4'(e_remote_amoswap), 5'd3,  X'(1),  Y'(2), 2'd0, 32'h0};
        tbl[6] = '{4'(e_remote_amoor),   5'd9,  X'(12), Y'(5), 2'd0, 32'h0};
        clear = 1'b1; step(); clear = 1'b0;
        chk("t2 cleared", {fc[0], err_v[0]}, 0);
        for (int k = 0; k < 7; k++) begin
            in_s[0].fwd.v = 1'b1;
            in_s[0].fwd.data = mk_pkt(tbl[k].op, tbl[k].reg_id, tbl[k].sx, tbl[k].sy, A'(k * 4));
            #1;
            chk("t2 ready", out_s[0].fwd.rdy, 1);
            step();
            e.typ = tbl[k].etyp; e.data = tbl[k].edata; e.reg_id = tbl[k].reg_id;
            e.y_cord = tbl[k].sy; e.x_cord = tbl[k].sx;
            chk("t2 ret_v", out_s[0].rev.v, 1);
            chk("t2 ret_pkt", out_s[0].rev.data, e);
            chk("t2 fwd_count", fc[0], k + 1);
        end
        in_s[0].fwd.v = 1'b0;
        step();
        chk("t2 drained", out_s[0].rev.v, 0);

        // return held under back-pressure, second request stalls
        clear = 1'b1; step(); clear = 1'b0;
        pa = mk_pkt(4'(e_remote_load), 5'd7, X'(4), Y'(2), A'(16'h0100));
        pb = mk_pkt(4'(e_remote_amoadd), 5'd8, X'(6), Y'(5), A'(16'h0104));
        in_s[0].rev.rdy = 1'b0;
        in_s[0].fwd.v = 1'b1; in_s[0].fwd.data = pa;
        step();
        in_s[0].fwd.data = pb;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t3 stall ready", out_s[0].fwd.rdy, 0);
            chk("t3 held ret_v", out_s[0].rev.v, 1);
            chk("t3 held ret_pkt", out_s[0].rev.data, exp_ret(pa));
            chk("t3 stalled count", fc[0], 1);
            step();
        end
        in_s[0].rev.rdy = 1'b1;
        #1;
        chk("t3 release ready", out_s[0].fwd.rdy, 1);
        step();
        in_s[0].fwd.v = 1'b0;
        chk("t3 second ret_v", out_s[0].rev.v, 1);
        chk("t3 second ret_pkt", out_s[0].rev.data, exp_ret(pb));
        chk("t3 fwd_count", fc[0], 2);
        step();
        chk("t3 drained", out_s[0].rev.v, 0);

        // 2-bit rev counter saturation and clear-with-event
        in2[0].rev.v = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in2[0].rev.data = ret_t'(k);
            step();
            chk("t4 rev_count sat", rc2[0], (k + 1 > 3) ? 3 : k + 1);
        end
        clear2 = 1'b1;
        step();
        chk("t4 clear+event", rc2[0], 1);
        in2[0].rev.v = 1'b0;
        step();
        clear2 = 1'b0;
        chk("t4 clear only", rc2[0], 0);

        // capture holds the first packet until cleared
        clear = 1'b1; step(); clear = 1'b0;
        pa = mk_pkt(4'(e_remote_store), 5'd1, X'(1), Y'(1), A'(16'h0200));
        pb = mk_pkt(4'(e_remote_store), 5'd1, X'(1), Y'(1), A'(16'h0300));
        in_s[0].fwd.v = 1'b1; in_s[0].fwd.data = pa;
        step();
        in_s[0].fwd.data = pb;
        step();
        in_s[0].fwd.v = 1'b0;
        chk("t5 cap keeps first", cap[0], pa);
        chk("t5 count", fc[0], 2);
        clear = 1'b1; step(); clear = 1'b0;
        chk("t5 cleared", {err_v[0], fc[0], cap[0]}, 0);
        p = mk_pkt(4'(e_remote_load), 5'd2, X'(2), Y'(2), A'(16'h0400));
        in_s[0].fwd.v = 1'b1; in_s[0].fwd.data = p;
        step();
        in_s[0].fwd.v = 1'b0;
        chk("t5 cap third", cap[0], p);
        p = mk_pkt(4'(e_remote_sw), 5'd3, X'(3), Y'(3), A'(16'h0500));
        in_s[0].fwd.v = 1'b1; in_s[0].fwd.data = p; clear = 1'b1;
        step();
        in_s[0].fwd.v = 1'b0; clear = 1'b0;
        chk("t5 clear+event cap", cap[0], p);
        chk("t5 clear+event count", {err_v[0], fc[0]}, {1'b1, 16'd1});
        step();

        // asynchronous reset with a return pending
        in_s[0].rev.rdy = 1'b0;
        in_s[0].fwd.v = 1'b1;
        in_s[0].fwd.data = mk_pkt(4'(e_remote_load), 5'd4, X'(1), Y'(2), A'(16'h0600));
        step();
        in_s[0].fwd.v = 1'b0;
        chk("t6 pending", out_s[0].rev.v, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 ret_v dropped", out_s[0].rev.v, 0);
        chk("t6 counters", {fc, rc, err_v}, 0);
        #2;
        rst = 1'b0;
        in_s[0].rev.rdy = 1'b1;
        step();
        chk("t6 ready after", out_s[0].fwd.rdy, 1);
        chk("t6 no answer", out_s[0].rev.v, 0);

        // randomized traffic on both channels against the queue model
        for (int c = 0; c < 2; c++) begin
            mq[c].delete(); mf[c] = 0; mr[c] = 0; me[c] = 0; mc[c] = '0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            clear = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < 2; c++) begin
                in_s[c].fwd.v    = ($urandom_range(0, 9) < 6);
                in_s[c].fwd.rdy  = 1'($urandom);
                in_s[c].fwd.data = rand_pkt();
                in_s[c].rev.v    = ($urandom_range(0, 9) < 3);
                rnd              = {$urandom, $urandom};
                in_s[c].rev.data = rnd[$bits(ret_t)-1:0];
                in_s[c].rev.rdy  = ($urandom_range(0, 9) < 6);
            end
            #1;
            for (int c = 0; c < 2; c++) begin
                bit rdy_exp;
                rdy_exp = (mq[c].size() == 0) || in_s[c].rev.rdy;
                chk("rand fwd_ready", out_s[c].fwd.rdy, rdy_exp);
                acc[c] = in_s[c].fwd.v && rdy_exp;
            end
            step();
            for (int c = 0; c < 2; c++) begin
                if (mq[c].size() != 0 && in_s[c].rev.rdy) mq[c].delete(0);
                if (acc[c]) mq[c].push_back(exp_ret(in_s[c].fwd.data));
                if (clear) begin
                    mf[c] = 0; mr[c] = 0; me[c] = 0; mc[c] = '0;
                end
                if (acc[c] && !me[c]) mc[c] = in_s[c].fwd.data;
                if (acc[c]) begin
                    me[c] = 1;
                    mf[c] = (mf[c] + 1 > 65535) ? 65535 : mf[c] + 1;
                end
                if (in_s[c].rev.v) mr[c] = (mr[c] + 1 > 65535) ? 65535 : mr[c] + 1;
                chk("rand ret_v", out_s[c].rev.v, (mq[c].size() != 0));
                if (mq[c].size() != 0) chk("rand ret_pkt", out_s[c].rev.data, mq[c][0]);
                chk("rand fwd_count", fc[c], mf[c]);
                chk("rand rev_count", rc[c], mr[c]);
                chk("rand err_v", err_v[c], me[c]);
                chk("rand cap", cap[c], mc[c]);
                chk("rand fwd_v_out", out_s[c].fwd.v, 0);
            end
        end
        clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
